// File: rtl/gray_sum_accumulator_pkg.sv
// Shared types and helpers for the Gray-sum accumulator and its neighbours.
package gray_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;

  localparam int unsigned GRAY_MAX_W = 32;

  // Binary to reflected Gray at the widest supported width; callers truncate.
  function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_sum_accumulator_if.sv
// Handshake bundle between the Gray adder side, the accumulator and the result consumer.
interface gray_sum_accumulator_if #(
  parameter int unsigned IN_W  = 6,
  parameter int unsigned ACC_W = 8
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_gray;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_bin;
  logic [ACC_W-1:0] out_gray;
  logic             overflow;
  logic             busy;

  modport master (
    output start, in_valid, in_gray, out_ready,
    input  in_ready, out_valid, out_bin, out_gray, overflow, busy
  );

  modport slave (
    input  start, in_valid, in_gray, out_ready,
    output in_ready, out_valid, out_bin, out_gray, overflow, busy
  );
endinterface

// File: rtl/gray_sum_accumulator_gray_to_bin.sv
// Purely combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end
endmodule

// File: rtl/gray_sum_accumulator.sv
// Accumulates a frame of COUNT Gray-coded sums into a wrapping binary total with sticky overflow,
// then holds the total in binary and Gray form until the consumer takes it.
module gray_sum_accumulator
  import gray_pkg::*;
#(
  parameter int unsigned IN_W  = 6,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned COUNT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_sum_accumulator_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(COUNT + 1);

  acc_state_t       r_state;
  acc_state_t       w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             w_load_out;
  logic [ACC_W-1:0] r_out_bin;
  logic [ACC_W-1:0] r_out_gray;
  logic [IN_W-1:0]  w_bin;
  logic [ACC_W:0]   w_sum;

  gray_to_bin #(.W(IN_W)) u_g2b (
    .i_gray (bus.in_gray),
    .o_bin  (w_bin)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus next accumulator, counter and overflow.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_load_out  = 1'b0;
    w_sum       = {1'b0, r_acc} + (ACC_W+1)'(w_bin);
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = ACCUM;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          w_acc_nxt = w_sum[ACC_W-1:0];
          w_ovf_nxt = r_ovf | w_sum[ACC_W];
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(COUNT - 1)) begin
            w_state_nxt = DONE;
            w_load_out  = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers; the result is captured on the final accept so it is stable through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_out_bin  <= '0;
      r_out_gray <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
      if (w_load_out) begin
        r_out_bin  <= w_acc_nxt;
        r_out_gray <= ACC_W'(bin_to_gray(GRAY_MAX_W'(w_acc_nxt)));
      end
    end
  end

  assign bus.in_ready  = (r_state == ACCUM);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.overflow  = r_ovf;
  assign bus.out_bin   = r_out_bin;
  assign bus.out_gray  = r_out_gray;
endmodule

// File: tb/tb_gray_sum_accumulator.sv
// Directed, table-driven bench for gray_sum_accumulator with hand-computed frame results.
module tb_gray_sum_accumulator;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  gray_sum_accumulator_if #(.IN_W(6), .ACC_W(8)) bus ();

  gray_sum_accumulator #(.IN_W(6), .ACC_W(8), .COUNT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] g;        // sample i in bits [i*6 +: 6]
    bit          gap;      // insert an in_valid=0 cycle between samples
    logic [7:0]  exp_bin;
    logic [7:0]  exp_gray;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] rep8(input logic [5:0] v);
    return {8{v}};
  endfunction

  task automatic run_frame(input int id, input logic [47:0] g, input bit gap,
                           input logic [7:0] eb, input logic [7:0] eg, input bit eo);
    // in_valid while IDLE must be ignored
    bus.in_valid = 1'b1; bus.in_gray = 6'h2A;
    step();
    chk($sformatf("v%0d idle_busy", id), 32'(bus.busy), 32'(0));
    chk($sformatf("v%0d idle_in_ready", id), 32'(bus.in_ready), 32'(0));
    bus.in_valid = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk($sformatf("v%0d start_in_ready", id), 32'(bus.in_ready), 32'(1));
    chk($sformatf("v%0d start_ovf_clr", id), 32'(bus.overflow), 32'(0));
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_gray = g[i*6 +: 6];
      step();
      if (i == 6) chk($sformatf("v%0d early_out_valid", id), 32'(bus.out_valid), 32'(0));
      if (gap && i < 7) begin
        bus.in_valid = 1'b0; bus.in_gray = 6'h3F;
        step();
      end
    end
    bus.in_valid = 1'b0;
    chk($sformatf("v%0d out_valid", id), 32'(bus.out_valid), 32'(1));
    chk($sformatf("v%0d done_in_ready", id), 32'(bus.in_ready), 32'(0));
    chk($sformatf("v%0d out_bin", id), 32'(bus.out_bin), 32'(eb));
    chk($sformatf("v%0d out_gray", id), 32'(bus.out_gray), 32'(eg));
    chk($sformatf("v%0d overflow", id), 32'(bus.overflow), 32'(eo));
    // in_valid while DONE must not disturb the result
    bus.in_valid = 1'b1; bus.in_gray = 6'h15;
    step();
    bus.in_valid = 1'b0;
    chk($sformatf("v%0d done_hold_bin", id), 32'(bus.out_bin), 32'(eb));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk($sformatf("v%0d post_busy", id), 32'(bus.busy), 32'(0));
    chk($sformatf("v%0d post_out_valid", id), 32'(bus.out_valid), 32'(0));
    chk($sformatf("v%0d post_ovf_sticky", id), 32'(bus.overflow), 32'(eo));
    chk($sformatf("v%0d post_bin_kept", id), 32'(bus.out_bin), 32'(eb));
  endtask

  initial begin
    vecs[0] = '{g: rep8(6'b000011), gap: 1'b0, exp_bin: 8'd16,  exp_gray: 8'h18, exp_ovf: 1'b0};
    vecs[1] = '{g: rep8(6'b100000), gap: 1'b0, exp_bin: 8'd248, exp_gray: 8'h84, exp_ovf: 1'b1};
    vecs[2] = '{g: {6'b001100, 6'b000100, 6'b000101, 6'b000111,
                    6'b000110, 6'b000010, 6'b000011, 6'b000001},
                gap: 1'b1, exp_bin: 8'd36, exp_gray: 8'h36, exp_ovf: 1'b0};
    vecs[3] = '{g: rep8(6'b110000), gap: 1'b0, exp_bin: 8'd0,   exp_gray: 8'h00, exp_ovf: 1'b1};
    vecs[4] = '{g: rep8(6'b110001), gap: 1'b1, exp_bin: 8'd8,   exp_gray: 8'h0C, exp_ovf: 1'b1};
    vecs[5] = '{g: rep8(6'b010000), gap: 1'b0, exp_bin: 8'd248, exp_gray: 8'h84, exp_ovf: 1'b0};

    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_gray = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst busy", 32'(bus.busy), 32'(0));
    chk("rst in_ready", 32'(bus.in_ready), 32'(0));
    chk("rst out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst overflow", 32'(bus.overflow), 32'(0));
    chk("rst out_bin", 32'(bus.out_bin), 32'(0));
    chk("rst out_gray", 32'(bus.out_gray), 32'(0));

    for (int v = 0; v < 6; v++)
      run_frame(v, vecs[v].g, vecs[v].gap, vecs[v].exp_bin, vecs[v].exp_gray, vecs[v].exp_ovf);

    // Backpressure in DONE, with start pulsed in ACCUM and in the transfer cycle
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_gray = 6'b000011;
      if (i == 3) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d out_valid", c), 32'(bus.out_valid), 32'(1));
      chk($sformatf("bp%0d in_ready", c), 32'(bus.in_ready), 32'(0));
      chk($sformatf("bp%0d out_bin", c), 32'(bus.out_bin), 32'(16));
      chk($sformatf("bp%0d out_gray", c), 32'(bus.out_gray), 32'(8'h18));
      step();
    end
    bus.out_ready = 1'b1; bus.start = 1'b1;
    step();
    bus.out_ready = 1'b0; bus.start = 1'b0;
    chk("bp xfer busy", 32'(bus.busy), 32'(0));
    chk("bp xfer out_valid", 32'(bus.out_valid), 32'(0));
    step();
    chk("bp stay idle busy", 32'(bus.busy), 32'(0));
    chk("bp stay idle in_ready", 32'(bus.in_ready), 32'(0));

    // Reset mid-frame after 4 accepts aborts without a result
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_gray = 6'b000011;
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", 32'(bus.busy), 32'(0));
    chk("midrst in_ready", 32'(bus.in_ready), 32'(0));
    chk("midrst out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst overflow", 32'(bus.overflow), 32'(0));
    chk("midrst out_bin", 32'(bus.out_bin), 32'(0));
    chk("midrst out_gray", 32'(bus.out_gray), 32'(0));
    run_frame(100, rep8(6'b000011), 1'b0, 8'd16, 8'h18, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
